coherence_bus: RTL and testbench

COHERENCE_BUS -- requirements
Module: coherence_bus

---
 rtl/coherence_bus.sv | 124 ++++++++++++
 tb/tb_coherence_bus.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus.sv
// rtl/coherence_bus.sv - two-cache snooping coherence bus arbiter in front of a single RAM port
// Optional macro BUS_C2C_FWD_EN: forward snooped dirty data straight to the requesting cache.
module coherence_bus #(
   parameter int CPUS = 2
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic [CPUS-1:0]        dREN,
   input  logic [CPUS-1:0]        dWEN,
   input  logic [CPUS-1:0]        ccwrite,
   input  logic [CPUS-1:0][31:0]  daddr,
   input  logic [CPUS-1:0][31:0]  dstore,
   output logic [CPUS-1:0]        dwait,
   output logic [CPUS-1:0][31:0]  dload,
   output logic [CPUS-1:0]        ccwait,
   output logic [CPUS-1:0]        ccinv,
   output logic [CPUS-1:0][31:0]  ccsnoopaddr,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [31:0]            ramaddr,
   output logic [31:0]            ramstore,
   input  logic [31:0]            ramload,
   input  logic [1:0]             ramstate
);

   // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3; only ACCESS completes a word
   localparam logic [1:0] ACCESS = 2'd2;

   typedef enum logic [2:0] {
      IDLE, WB, INV, SNOOP, FWD0, FWD1, RD0, RD1
   } state_t;

   state_t          state, next_state;
   logic            r, s, last_grant, grant;
   logic [CPUS-1:0] req;
   logic            access;

   assign s      = ~r;
   assign access = (ramstate == ACCESS);
   assign req    = dREN | dWEN | ccwrite;
   assign grant  = (req == 2'b11) ? ~last_grant : req[1];

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         r          <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && |req) begin
            r          <= grant;
            last_grant <= grant;
         end
      end
   end

   always_comb begin
      next_state  = state;
      dwait       = '1;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      case (state)
         IDLE: begin
            // ccwait is never driven in IDLE, so a bare ccwrite is a write-hit notice here
            if (|req) begin
               if (dWEN[grant])      next_state = WB;
               else if (dREN[grant]) next_state = SNOOP;
               else                  next_state = INV;
            end
         end
         WB: begin
            ramWEN   = 1'b1;
            ramaddr  = daddr[r];
            ramstore = dstore[r];
            dwait[r] = ~access;
            if (access) next_state = IDLE;
         end
         INV: begin
            ccwait[s]      = 1'b1;
            ccinv[s]       = 1'b1;
            ccsnoopaddr[s] = daddr[r];
            dwait[r]       = 1'b0;
            next_state     = IDLE;
         end
         SNOOP: begin
            ccwait[s]      = 1'b1;
            ccsnoopaddr[s] = daddr[r];
            next_state     = ccwrite[s] ? FWD0 : RD0;
         end
         FWD0, FWD1: begin
            ccwait[s]      = 1'b1;
            ccsnoopaddr[s] = daddr[r];
            ramWEN         = 1'b1;
            ramaddr        = daddr[s];
            ramstore       = dstore[s];
            if (access) begin
               dwait[s] = 1'b0;
`ifdef BUS_C2C_FWD_EN
               dwait[r] = 1'b0;
               dload[r] = dstore[s];
               next_state = (state == FWD0) ? FWD1 : IDLE;
`else
               next_state = (state == FWD0) ? FWD1 : RD0;
`endif
            end
         end
         RD0, RD1: begin
            ramREN   = 1'b1;
            ramaddr  = daddr[r];
            dload[r] = ramload;
            dwait[r] = ~access;
            if (access) next_state = (state == RD0) ? RD1 : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_coherence_bus.sv
// tb/tb_coherence_bus.sv - scoreboard bench for coherence_bus (honours BUS_C2C_FWD_EN)
module tb_coherence_bus;

   logic              CLK = 1'b0;
   logic              nRST;
   logic [1:0]        dREN, dWEN, ccwrite;
   logic [1:0][31:0]  daddr, dstore;
   logic [1:0]        dwait;
   logic [1:0][31:0]  dload;
   logic [1:0]        ccwait, ccinv;
   logic [1:0][31:0]  ccsnoopaddr;
   logic              ramREN, ramWEN;
   logic [31:0]       ramaddr, ramstore, ramload;
   logic [1:0]        ramstate;

   localparam logic [1:0] BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

   typedef struct packed {
      logic [1:0]  dw;
      logic [31:0] l0, l1;
      logic [1:0]  cw, ci;
      logic [31:0] a0, a1;
      logic        rr, rw;
      logic [31:0] ad, st;
   } snap_t;

   snap_t expq[$];
   string tagq[$];
   int    total = 0;
   int    bad   = 0;
   bit    mon_en = 1'b0;
   snap_t act_s, exp_s;
   string tag_s;

   always #5 CLK = ~CLK;

   coherence_bus #(.CPUS(2)) dut (
      .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite),
      .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   function automatic snap_t mk(input logic [1:0] dw, input logic [31:0] l0, l1,
                                input logic [1:0] cw, ci, input logic [31:0] a0, a1,
                                input logic rr, rw, input logic [31:0] ad, st);
      snap_t x;
      x.dw = dw; x.l0 = l0; x.l1 = l1; x.cw = cw; x.ci = ci;
      x.a0 = a0; x.a1 = a1; x.rr = rr; x.rw = rw; x.ad = ad; x.st = st;
      return x;
   endfunction

   // every non-idle output cycle is a bus event and must match the next scoreboard entry
   always @(negedge CLK) begin
      if (mon_en) begin
         act_s = mk(dwait, dload[0], dload[1], ccwait, ccinv, ccsnoopaddr[0],
                    ccsnoopaddr[1], ramREN, ramWEN, ramaddr, ramstore);
         if (act_s != mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            total++;
            if (expq.size() == 0) begin
               bad++;
               $display("FAIL unexpected_event actual=%h required=none", act_s);
            end else begin
               exp_s = expq.pop_front();
               tag_s = tagq.pop_front();
               if (act_s !== exp_s) begin
                  bad++;
                  $display("FAIL %s actual=%h required=%h", tag_s, act_s, exp_s);
               end
            end
         end
      end
   end

   task automatic step(input bit act, input string tag, input snap_t e);
      if (act) begin
         expq.push_back(e);
         tagq.push_back(tag);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", n, a, e);
      end
   endtask

   task automatic idle_checks(input string n);
      chk({n, "_dwait"}, 64'(dwait), 64'h3);
      chk({n, "_ramREN"}, 64'(ramREN), 64'h0);
      chk({n, "_ramWEN"}, 64'(ramWEN), 64'h0);
      chk({n, "_ccwait"}, 64'(ccwait), 64'h0);
   endtask

   initial begin
      logic [1:0]  one;
      logic [31:0] ca [2];
      logic [31:0] cs [2];
      one = 2'b01;
      ca[0] = 32'h300; ca[1] = 32'h400;
      cs[0] = 32'h30;  cs[1] = 32'h40;
      nRST = 1'b0; dREN = '0; dWEN = '0; ccwrite = '0;
      daddr = '0; dstore = '0; ramload = '0; ramstate = BUSY;
      @(posedge CLK); @(posedge CLK); #1;
      idle_checks("reset");
      nRST = 1'b1;
      mon_en = 1'b1;

      // read miss, no sharer
      dREN = 2'b01; daddr[0] = 32'h100; ramload = 32'hAAAA;
      step(0, "", '0);
      step(1, "miss_snoop", mk(2'b11, 0, 0, 2'b10, 0, 0, 32'h100, 0, 0, 0, 0));
      step(1, "miss_rd0_busy", mk(2'b11, 32'hAAAA, 0, 0, 0, 0, 0, 1, 0, 32'h100, 0));
      ramstate = ACC;
      step(1, "miss_rd0", mk(2'b10, 32'hAAAA, 0, 0, 0, 0, 0, 1, 0, 32'h100, 0));
      daddr[0] = 32'h104; ramload = 32'hBBBB;
      step(1, "miss_rd1", mk(2'b10, 32'hBBBB, 0, 0, 0, 0, 0, 1, 0, 32'h104, 0));
      dREN = 2'b00; daddr[0] = 32'h100;
      step(0, "", '0);

      // read hits dirty line in cache 1
      dREN = 2'b01; ramstate = BUSY;
      step(0, "", '0);
      ccwrite = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'h1234;
      step(1, "hit_snoop", mk(2'b11, 0, 0, 2'b10, 0, 0, 32'h100, 0, 0, 0, 0));
      step(1, "hit_fwd0_busy", mk(2'b11, 0, 0, 2'b10, 0, 0, 32'h100, 0, 1, 32'h100, 32'h1234));
      ramstate = ACC;
`ifdef BUS_C2C_FWD_EN
      step(1, "hit_fwd0", mk(2'b00, 32'h1234, 0, 2'b10, 0, 0, 32'h100, 0, 1, 32'h100, 32'h1234));
      daddr[1] = 32'h104; dstore[1] = 32'h5678;
      step(1, "hit_fwd1", mk(2'b00, 32'h5678, 0, 2'b10, 0, 0, 32'h100, 0, 1, 32'h104, 32'h5678));
      dREN = 2'b00; ccwrite = 2'b00;
      step(0, "", '0);
`else
      step(1, "hit_wb0", mk(2'b01, 0, 0, 2'b10, 0, 0, 32'h100, 0, 1, 32'h100, 32'h1234));
      daddr[1] = 32'h104; dstore[1] = 32'h5678;
      step(1, "hit_wb1", mk(2'b01, 0, 0, 2'b10, 0, 0, 32'h100, 0, 1, 32'h104, 32'h5678));
      ccwrite = 2'b00; ramload = 32'hCAFE;
      step(1, "hit_rd0", mk(2'b10, 32'hCAFE, 0, 0, 0, 0, 0, 1, 0, 32'h100, 0));
      daddr[0] = 32'h104; ramload = 32'hBEEF;
      step(1, "hit_rd1", mk(2'b10, 32'hBEEF, 0, 0, 0, 0, 0, 1, 0, 32'h104, 0));
      dREN = 2'b00;
      step(0, "", '0);
`endif

      // write hit from cache 1 invalidates cache 0
      ccwrite = 2'b10; daddr[1] = 32'h208;
      step(0, "", '0);
      step(1, "inv", mk(2'b01, 0, 0, 2'b01, 2'b01, 32'h208, 0, 0, 0, 0, 0));
      ccwrite = 2'b00;
      step(0, "", '0);

      // contention after reset: grants alternate starting with cache 0
      nRST = 1'b0;
      step(0, "", '0);
      nRST = 1'b1;
      dWEN = 2'b11; daddr[0] = ca[0]; daddr[1] = ca[1]; dstore[0] = cs[0]; dstore[1] = cs[1];
      ramstate = BUSY;
      step(0, "", '0);
      for (int i = 0; i < 4; i++) begin
         ramstate = (i == 0) ? ERR : BUSY;
         step(1, $sformatf("wb%0d_stall", i), mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 1, ca[i%2], cs[i%2]));
         ramstate = ACC;
         step(1, $sformatf("wb%0d_ack", i), mk(~(one << (i%2)), 0, 0, 0, 0, 0, 0, 0, 1, ca[i%2], cs[i%2]));
         if (i == 3) dWEN = 2'b00;
         ramstate = BUSY;
         step(0, "", '0);
      end

      // reset in the middle of RD0
      dREN = 2'b01; daddr[0] = 32'h500; ramload = 32'h55;
      step(0, "", '0);
      step(1, "rst_snoop", mk(2'b11, 0, 0, 2'b10, 0, 0, 32'h500, 0, 0, 0, 0));
      step(1, "rst_rd0", mk(2'b11, 32'h55, 0, 0, 0, 0, 0, 1, 0, 32'h500, 0));
      nRST = 1'b0;
      step(1, "rst_rd0_hold", mk(2'b11, 32'h55, 0, 0, 0, 0, 0, 1, 0, 32'h500, 0));
      nRST = 1'b1; dREN = 2'b00;
      idle_checks("midreset");
      step(0, "", '0);
      step(0, "", '0);

      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL missing_events actual=%0d required=0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
